button_debounce_array: RTL and testbench



---
 rtl/button_debounce_array.sv | 129 ++++++++++++
 tb/tb_button_debounce_array.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_array.sv
// button_debounce_array: per-channel 2-flop sync + stability-counter debounce with press/release pulses.
// Define BUTTON_LONG_PRESS_EN to build the per-channel long-press hold counters.
module button_debounce_array #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 250000,
    parameter int LONG_CYCLES   = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_e;

    if (CHANNELS < 1 || CHANNELS > 32 || STABLE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
        $error("button_debounce_array: parameter out of range");
    end

    logic [CHANNELS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_q, press_d, rel_q, rel_d;
        logic          s;
        assign s = sync2_q[c];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                LOW: if (s) begin
                    state_d = RISE;
                    cnt_d   = CW'(1);
                end
                RISE: if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else cnt_d = cnt_q + CW'(1);
                HIGH: if (!s) begin
                    state_d = FALL;
                    cnt_d   = CW'(1);
                end
                default: if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else cnt_d = cnt_q + CW'(1);
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= LOW;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign level[c]         = (state_q == HIGH) || (state_q == FALL);
        assign press[c]         = press_q;
        assign release_pulse[c] = rel_q;

`ifdef BUTTON_LONG_PRESS_EN
        localparam int HW = $clog2(LONG_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
        logic [HW-1:0] hold_q, hold_d;
        logic          long_q, long_d;

        // The counter parks at LONG_CYCLES so the pulse fires once per press; release wins over long-press.
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (state_q == RISE && state_d == HIGH) hold_d = '0;
            else if ((state_q == HIGH || state_q == FALL) && state_d != LOW) begin
                if (hold_q < HOLD_LAST) hold_d = hold_q + HW'(1);
                else if (hold_q == HOLD_LAST) begin
                    hold_d = HW'(LONG_CYCLES);
                    long_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign long_press[c] = long_q;
`else
        assign long_press[c] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_button_debounce_array.sv
// tb_button_debounce_array: directed stimulus with a run-length debounce model checked every cycle.
module tb_button_debounce_array;
    localparam int S = 4;
    localparam int L = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] button = 4'h0;
    logic [3:0] level, press, release_pulse, long_press;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] b1, b2, m_level, m_press, m_rel, m_long;
    int run[4];
    int age[4];

    button_debounce_array #(.CHANNELS(4), .STABLE_CYCLES(S), .LONG_CYCLES(L)) dut (
        .clk(clk),
        .rst(rst),
        .button(button),
        .level(level),
        .press(press),
        .release_pulse(release_pulse),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Level flips once S consecutive synchronised samples disagree with it; long-press fires L edges after press.
    task automatic step_model();
        logic [3:0] s;
        if (!rst) begin
            b1 = '0; b2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < 4; i++) begin
                run[i] = 0;
                age[i] = 0;
            end
        end else begin
            s = b2;
            b2 = b1;
            b1 = button;
            for (int i = 0; i < 4; i++) begin
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                m_long[i]  = 1'b0;
                run[i] = (s[i] != m_level[i]) ? run[i] + 1 : 0;
                if (run[i] == S) begin
                    run[i]     = 0;
                    m_level[i] = ~m_level[i];
                    m_press[i] = m_level[i];
                    m_rel[i]   = ~m_level[i];
                    age[i]     = 0;
                end else if (m_level[i]) begin
                    age[i]++;
`ifdef BUTTON_LONG_PRESS_EN
                    m_long[i] = (age[i] == L);
`endif
                end
            end
        end
    endtask

    always begin
        @(posedge clk);
        step_model();
        #1;
        check("level", level, m_level);
        check("press", press, m_press);
        check("release", release_pulse, m_rel);
        check("long_press", long_press, m_long);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int long_cnt;
    int long_at;

    initial begin
        rst = 1'b0;
        button = 4'hF;
        tick(3);
        check("rst_level", level, 4'h0);
        check("rst_press", press, 4'h0);
        rst = 1'b1;
        tick(5);
        check("held_press_early", press, 4'h0);
        tick(1);
        check("held_press", press, 4'hF);
        check("held_level", level, 4'hF);
        tick(1);
        check("held_press_width", press, 4'h0);
        button = 4'h0;
        tick(8);
        check("all_released", level, 4'h0);

        button[0] = 1'b1;
        tick(5);
        check("ch0_press_early", press, 4'h0);
        tick(1);
        check("ch0_press", press, 4'h1);
        check("ch0_level", level, 4'h1);
        tick(1);
        button[0] = 1'b0;
        tick(5);
        check("ch0_rel_early", release_pulse, 4'h0);
        tick(1);
        check("ch0_release", release_pulse, 4'h1);
        check("ch0_level_low", level, 4'h0);
        tick(4);

        for (int k = 0; k < 3; k++) begin
            button[1] = 1'b1;
            tick(3);
            button[1] = 1'b0;
            tick(3);
        end
        tick(6);
        check("ch1_bounce_level", level, 4'h0);

        button[2] = 1'b1;
        tick(8);
        check("ch2_high", level, 4'h4);
        button[2] = 1'b0;
        tick(2);
        button[2] = 1'b1;
        tick(10);
        check("ch2_glitch_level", level, 4'h4);
        button[2] = 1'b0;
        tick(8);
        check("ch2_low", level, 4'h0);

        button[3] = 1'b1;
        tick(6);
        check("ch3_press", press, 4'h8);
        long_cnt = 0;
        long_at = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (long_press[3]) begin
                long_cnt++;
                long_at = k;
            end
        end
`ifdef BUTTON_LONG_PRESS_EN
        check("ch3_long_count", 4'(long_cnt), 4'd1);
        check("ch3_long_delay", 4'(long_at), 4'd10);
`else
        check("ch3_long_count", 4'(long_cnt), 4'd0);
`endif
        button[3] = 1'b0;
        tick(8);

        button[0] = 1'b1;
        tick(6);
        check("ch0_press2", press, 4'h1);
        tick(2);
        rst = 1'b0;
        #1;
        check("midrst_level", level, 4'h0);
        check("midrst_press", press, 4'h0);
        check("midrst_release", release_pulse, 4'h0);
        check("midrst_long", long_press, 4'h0);
        tick(3);
        rst = 1'b1;
        button = 4'h0;
        tick(8);
        check("after_rst_level", level, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
